// File: rtl/async_operator_fifo.sv
// Dataflow operator that joins 1..3 operand channels, applies a fixed op and buffers
// results in a multi-reader FIFO. Define ASYNC_OPERATOR_FIFO_STATS_EN for push/full counters.
module async_operator_fifo #(
  parameter int    data_width  = 32,
  parameter string op          = "reg",
  parameter int    immediate   = 0,
  parameter int    input_size  = 1,
  parameter int    output_size = 1,
  parameter int    depth_log2  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [input_size-1:0]             req_l,
  input  logic [input_size-1:0]             ack_l,
  input  logic [data_width*input_size-1:0]  din,
  input  logic [output_size-1:0]            req_r,
  output logic [output_size-1:0]            ack_r,
  output logic [data_width*output_size-1:0] dout
`ifdef ASYNC_OPERATOR_FIFO_STATS_EN
  ,
  output logic [31:0]                       count_push,
  output logic [31:0]                       count_full
`endif
);

  localparam int Depth = 1 << depth_log2;
  localparam int PW    = depth_log2 + 1;
  localparam logic [data_width-1:0] ImmW = data_width'(immediate);

  typedef enum logic [3:0] {
    OP_REG, OP_ADDI, OP_SUBI, OP_MULI, OP_ADD, OP_SUB, OP_MUL, OP_MIN, OP_MAX
  } op_e;

  // "reg", "in" and "out" are all plain pass-through of operand 0.
  localparam op_e OpSel = (op == "addi") ? OP_ADDI :
                          (op == "subi") ? OP_SUBI :
                          (op == "muli") ? OP_MULI :
                          (op == "add")  ? OP_ADD  :
                          (op == "sub")  ? OP_SUB  :
                          (op == "mul")  ? OP_MUL  :
                          (op == "min")  ? OP_MIN  :
                          (op == "max")  ? OP_MAX  : OP_REG;

  logic [input_size-1:0]                   req_l_q, req_l_d, has_q, has_d;
  logic [input_size-1:0][data_width-1:0]   opnd_q, opnd_d;
  logic [PW-1:0]                           wr_ptr_q, wr_ptr_d;
  logic [output_size-1:0][PW-1:0]          rd_ptr_q, rd_ptr_d, occ;
  logic [output_size-1:0]                  ack_r_q, ack_r_d;
  logic [output_size-1:0][data_width-1:0]  dout_q, dout_d;
  logic [data_width-1:0]                   mem_q [Depth];
  logic [data_width-1:0]                   result;
  logic                                    full, push;

  // A result can only enter when no consumer's view of the FIFO is full.
  always_comb begin
    full = 1'b0;
    for (int k = 0; k < output_size; k++) begin
      occ[k] = wr_ptr_q - rd_ptr_q[k];
      if (occ[k] == PW'(Depth)) full = 1'b1;
    end
    push = (&has_q) & ~full;
  end

  always_comb begin
    result = opnd_q[0];
    case (OpSel)
      OP_ADDI: result = result + ImmW;
      OP_SUBI: result = result - ImmW;
      OP_MULI: result = result * ImmW;
      default: ;
    endcase
    for (int i = 1; i < input_size; i++) begin
      case (OpSel)
        OP_ADD:  result = result + opnd_q[i];
        OP_SUB:  result = result - opnd_q[i];
        OP_MUL:  result = result * opnd_q[i];
        OP_MIN:  result = (opnd_q[i] < result) ? opnd_q[i] : result;
        OP_MAX:  result = (opnd_q[i] > result) ? opnd_q[i] : result;
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_l_d  = req_l_q;
    has_d    = has_q;
    opnd_d   = opnd_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    for (int i = 0; i < input_size; i++) begin
      if (push) has_d[i] = 1'b0;
      if (~has_q[i] & ~req_l_q[i]) req_l_d[i] = 1'b1;
      if (ack_l[i]) begin
        opnd_d[i]  = din[data_width*i +: data_width];
        has_d[i]   = 1'b1;
        req_l_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    ack_r_d  = '0;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    for (int k = 0; k < output_size; k++) begin
      if (req_r[k] & ~ack_r_q[k] & (occ[k] != '0)) begin
        ack_r_d[k]  = 1'b1;
        dout_d[k]   = mem_q[rd_ptr_q[k][depth_log2-1:0]];
        rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_l_q  <= '0;
      has_q    <= '0;
      opnd_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ack_r_q  <= '0;
      dout_q   <= '0;
    end else begin
      req_l_q  <= req_l_d;
      has_q    <= has_d;
      opnd_q   <= opnd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_r_q  <= ack_r_d;
      dout_q   <= dout_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[depth_log2-1:0]] <= result;
  end

  assign req_l = req_l_q;
  assign ack_r = ack_r_q;
  assign dout  = dout_q;

`ifdef ASYNC_OPERATOR_FIFO_STATS_EN
  logic [31:0] count_push_q, count_full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_push_q <= '0;
      count_full_q <= '0;
    end else begin
      if (push && count_push_q != '1) count_push_q <= count_push_q + 32'd1;
      if ((&has_q) && full && count_full_q != '1) count_full_q <= count_full_q + 32'd1;
    end
  end

  assign count_push = count_push_q;
  assign count_full = count_full_q;
`endif

endmodule

// File: tb/tb_async_operator_fifo.sv
// Directed bench for async_operator_fifo: several parameterisations share one clock and reset.
module tb_async_operator_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // add, 2 inputs
  logic [1:0]  req_l_add, ack_l_add = '0;
  logic [15:0] din_add = '0;
  logic        req_r_add = 1'b0, ack_r_add;
  logic [7:0]  dout_add;
  // addi imm 2
  logic        req_l_adi, ack_l_adi = 1'b0;
  logic [7:0]  din_adi = '0;
  logic        req_r_adi = 1'b0, ack_r_adi;
  logic [7:0]  dout_adi;
  // max, 3 inputs
  logic [2:0]  req_l_max, ack_l_max = '0;
  logic [23:0] din_max = '0;
  logic        req_r_max = 1'b0, ack_r_max;
  logic [7:0]  dout_max;
  // sub, 3 inputs
  logic [2:0]  req_l_sub, ack_l_sub = '0;
  logic [23:0] din_sub = '0;
  logic        req_r_sub = 1'b0, ack_r_sub;
  logic [7:0]  dout_sub;
  // min, 2 inputs
  logic [1:0]  req_l_min, ack_l_min = '0;
  logic [15:0] din_min = '0;
  logic        req_r_min = 1'b0, ack_r_min;
  logic [7:0]  dout_min;
  // reg, backpressure
  logic        req_l_bp, ack_l_bp = 1'b0;
  logic [7:0]  din_bp = '0;
  logic        req_r_bp = 1'b0, ack_r_bp;
  logic [7:0]  dout_bp;
  // reg, 2 consumers
  logic        req_l_fan, ack_l_fan = 1'b0;
  logic [7:0]  din_fan = '0;
  logic [1:0]  req_r_fan = '0, ack_r_fan;
  logic [15:0] dout_fan;

`ifdef ASYNC_OPERATOR_FIFO_STATS_EN
  logic [31:0] cp_add, cf_add, cp_adi, cf_adi, cp_max, cf_max, cp_sub, cf_sub;
  logic [31:0] cp_min, cf_min, cp_bp, cf_bp, cp_fan, cf_fan;
  `define STATS(p, f) , .count_push(p), .count_full(f)
`else
  `define STATS(p, f)
`endif

  async_operator_fifo #(.data_width(8), .op("add"), .input_size(2), .depth_log2(2)) u_add (
    .clk(clk), .rst(rst), .req_l(req_l_add), .ack_l(ack_l_add), .din(din_add),
    .req_r(req_r_add), .ack_r(ack_r_add), .dout(dout_add) `STATS(cp_add, cf_add));
  async_operator_fifo #(.data_width(8), .op("addi"), .immediate(2)) u_adi (
    .clk(clk), .rst(rst), .req_l(req_l_adi), .ack_l(ack_l_adi), .din(din_adi),
    .req_r(req_r_adi), .ack_r(ack_r_adi), .dout(dout_adi) `STATS(cp_adi, cf_adi));
  async_operator_fifo #(.data_width(8), .op("max"), .input_size(3)) u_max (
    .clk(clk), .rst(rst), .req_l(req_l_max), .ack_l(ack_l_max), .din(din_max),
    .req_r(req_r_max), .ack_r(ack_r_max), .dout(dout_max) `STATS(cp_max, cf_max));
  async_operator_fifo #(.data_width(8), .op("sub"), .input_size(3)) u_sub (
    .clk(clk), .rst(rst), .req_l(req_l_sub), .ack_l(ack_l_sub), .din(din_sub),
    .req_r(req_r_sub), .ack_r(ack_r_sub), .dout(dout_sub) `STATS(cp_sub, cf_sub));
  async_operator_fifo #(.data_width(8), .op("min"), .input_size(2)) u_min (
    .clk(clk), .rst(rst), .req_l(req_l_min), .ack_l(ack_l_min), .din(din_min),
    .req_r(req_r_min), .ack_r(ack_r_min), .dout(dout_min) `STATS(cp_min, cf_min));
  async_operator_fifo #(.data_width(8), .op("reg"), .output_size(1), .depth_log2(2)) u_bp (
    .clk(clk), .rst(rst), .req_l(req_l_bp), .ack_l(ack_l_bp), .din(din_bp),
    .req_r(req_r_bp), .ack_r(ack_r_bp), .dout(dout_bp) `STATS(cp_bp, cf_bp));
  async_operator_fifo #(.data_width(8), .op("reg"), .output_size(2), .depth_log2(2)) u_fan (
    .clk(clk), .rst(rst), .req_l(req_l_fan), .ack_l(ack_l_fan), .din(din_fan),
    .req_r(req_r_fan), .ack_r(ack_r_fan), .dout(dout_fan) `STATS(cp_fan, cf_fan));

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cap5, r1, seen_req, seen_ack, n_bp, sent6, sent, n0, n1, lag, max_lag;

    // Asynchronous reset with the clock stopped
    #2 rst = 1'b0;
    #1;
    check("rst_req_l", 32'(req_l_add), 32'h0);
    check("rst_ack_r", 32'(ack_r_add), 32'h0);
    check("rst_dout", 32'(dout_add), 32'h0);
    req_r_add = 1'b1; req_r_adi = 1'b1; req_r_max = 1'b1;
    req_r_sub = 1'b1; req_r_min = 1'b1;
    #7 clk_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rel_req_l_before_edge", 32'(req_l_add), 32'h0);
    tick();
    check("rel_req_l", 32'(req_l_add), 32'h3);

    // Basic add: ack_l sampled at edge E0, ack_r rises at E0+2
    ack_l_add = 2'b11; din_add = {8'd7, 8'd5};
    tick();
    ack_l_add = 2'b00;
    check("add_req_l_clr", 32'(req_l_add), 32'h0);
    check("add_ack_e1", 32'(ack_r_add), 32'h0);
    tick();
    check("add_ack_e2", 32'(ack_r_add), 32'h0);
    tick();
    check("add_ack", 32'(ack_r_add), 32'h1);
    check("add_dout", 32'(dout_add), 32'd12);
    check("add_req_l_again", 32'(req_l_add), 32'h3);
    tick();
    check("add_ack_pulse", 32'(ack_r_add), 32'h0);
    check("add_dout_hold", 32'(dout_add), 32'd12);

    // addi wraps at 8 bits
    ack_l_adi = 1'b1; din_adi = 8'hFF;
    tick();
    ack_l_adi = 1'b0;
    tick();
    tick();
    check("addi_ack", 32'(ack_r_adi), 32'h1);
    check("addi_dout", 32'(dout_adi), 32'h01);

    // max is unsigned
    ack_l_max = 3'b111; din_max = {8'h01, 8'h7F, 8'h80};
    tick();
    ack_l_max = 3'b000;
    tick();
    tick();
    check("max_ack", 32'(ack_r_max), 32'h1);
    check("max_dout", 32'(dout_max), 32'h80);

    // min is unsigned
    ack_l_min = 2'b11; din_min = {8'h7F, 8'h80};
    tick();
    ack_l_min = 2'b00;
    tick();
    tick();
    check("min_dout", 32'(dout_min), 32'h7F);

    // sub with operands arriving on different cycles: 10-3-2
    ack_l_sub = 3'b001; din_sub = {8'd0, 8'd0, 8'd10};
    tick();
    ack_l_sub = 3'b000;
    check("sub_req_l_partial", 32'(req_l_sub), 32'h6);
    tick();
    tick();
    check("sub_no_early_ack", 32'(ack_r_sub), 32'h0);
    ack_l_sub = 3'b110; din_sub = {8'd2, 8'd3, 8'd0};
    tick();
    ack_l_sub = 3'b000;
    tick();
    tick();
    check("sub_ack", 32'(ack_r_sub), 32'h1);
    check("sub_dout", 32'(dout_sub), 32'h05);
    check("sub_req_l_again", 32'(req_l_sub), 32'h7);
    // 1-2-3 wraps to 0xFC
    ack_l_sub = 3'b111; din_sub = {8'd3, 8'd2, 8'd1};
    tick();
    ack_l_sub = 3'b000;
    tick();
    tick();
    check("sub_wrap_dout", 32'(dout_sub), 32'hFC);

    // Full backpressure: 4 stored, 5th held in the operand register
    cap5 = 0;
    for (int v = 0; v < 5; v++) begin
      for (int t = 0; t < 10 && !req_l_bp; t++) tick();
      check("bp_req_l", 32'(req_l_bp), 32'h1);
      ack_l_bp = 1'b1; din_bp = 8'(v);
      tick();
      ack_l_bp = 1'b0;
      cap5 = cyc;
    end
    seen_req = 0; seen_ack = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (req_l_bp) seen_req++;
      if (ack_r_bp) seen_ack++;
    end
    check("bp_req_l_held_low", 32'(seen_req), 32'd0);
    check("bp_no_ack_without_req", 32'(seen_ack), 32'd0);
    req_r_bp = 1'b1;
    r1 = cyc + 1;
    n_bp = 0; sent6 = 0;
    for (int t = 0; t < 60; t++) begin
      tick();
      ack_l_bp = 1'b0;
      if (ack_r_bp) begin
        check("bp_order", 32'(dout_bp), 32'(n_bp));
        n_bp++;
      end
      if (req_l_bp && sent6 == 0) begin
        ack_l_bp = 1'b1; din_bp = 8'd5; sent6 = 1;
      end
    end
    check("bp_sixth_requested", 32'(sent6), 32'd1);
    check("bp_count", 32'(n_bp), 32'd6);
`ifdef ASYNC_OPERATOR_FIFO_STATS_EN
    check("stats_count_push", cp_bp, 32'd6);
    check("stats_count_full", cf_bp, 32'(r1 - cap5));
`endif

    // Independent fan-out: consumer 1 requests only every 5th cycle
    sent = 0; n0 = 0; n1 = 0; max_lag = 0;
    for (int t = 0; t < 400 && !(n0 == 10 && n1 == 10); t++) begin
      tick();
      ack_l_fan = 1'b0;
      if (ack_r_fan[0]) begin
        check("fan_c0_order", 32'(dout_fan[7:0]), 32'(n0));
        n0++;
      end
      if (ack_r_fan[1]) begin
        check("fan_c1_order", 32'(dout_fan[15:8]), 32'(n1));
        n1++;
      end
      if (req_l_fan && sent < 10) begin
        ack_l_fan = 1'b1; din_fan = 8'(sent); sent++;
      end
      lag = sent - n1;
      if (lag > max_lag) max_lag = lag;
      req_r_fan = {(cyc % 5) == 0, 1'b1};
    end
    check("fan_c0_count", 32'(n0), 32'd10);
    check("fan_c1_count", 32'(n1), 32'd10);
    check("fan_c1_lag_bound", 32'(max_lag <= 5), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/async_operator_fifo.md
Name: async_operator_fifo

Overview:
- Parametrised successor of the dataflow handshake operator.
- Joins `input_size` operand channels (1..3) and applies `op`.
- Pushes each result into a `depth`-entry FIFO that feeds `output_size` consumers.
- Each consumer has its own read pointer and ack, so fan-out branches drain independently and no longer lock-step.
- Placed between dataflow nodes inside arf graphs to absorb path imbalance instead of chains of reg operators.

Parameters:
- data_width, 32, operand/result width.
- op, "reg", one of reg/in/out/addi/subi/muli (input_size=1), add/sub/mul/min/max (input_size 2 or 3).
- immediate, 0, constant for addi/subi/muli.
- input_size, 1, operand channels, 1..3.
- output_size, 1, consumer channels, 1..8.
- depth_log2, 2, FIFO depth = 2**depth_log2, 1..6.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- req_l  output  input_size  operand request per input channel.
- ack_l  input  input_size  one-cycle operand-valid pulse from producer.
- din  input  data_width*input_size  operands; channel i at [data_width*(i+1)-1:data_width*i].
- req_r  input  output_size  consumer request per output channel.
- ack_r  output  output_size  one-cycle result-valid pulse per consumer.
- dout  output  data_width*output_size  per-consumer result, packed like din.

Behaviour:
- Reset (rst=0, immediate, no clock needed):
  - req_l=0, ack_r=0, dout=0, has=0.
  - wr_ptr=0 and all rd_ptr[k]=0; pointers are depth_log2+1 bits.
  - FIFO contents are don't-care.
  - Reset mid-transfer discards captured operands and all stored entries.
- Input side, per channel i, each cycle:
  - If ~has[i] & ~req_l[i], set req_l[i]<=1.
  - If ack_l[i], capture din slice i into opnd[i] on the clock edge (synchronous capture, no ack-edge clocking), has[i]<=1, req_l[i]<=0.
  - ack_l while has[i]=1 is a protocol violation; the capture still overwrites.
- Push:
  - When &has and not full: mem[wr_ptr]<=op(opnd), wr_ptr+1, has<=0.
  - Push happens on the edge after the last operand capture. Minimum ack_l-to-stored latency is 1 cycle.
  - When full, has stays set and req_l stays 0. This is backpressure.
- Arithmetic: result truncated to data_width (wrap, unsigned). Operand 0 is the first term: sub = op0-op1-op2. min/max are unsigned.
- Occupancy:
  - occ[k] = wr_ptr - rd_ptr[k], modulo 2**(depth_log2+1).
  - full when any occ[k] == depth.
  - An entry is freed only after every consumer has read it.
  - Push and the freeing read in the same cycle is permitted only if not full at the start of that cycle. There is no same-cycle bypass.
- Output side, per consumer k, each cycle:
  - ack_r[k]<=0 by default.
  - If req_r[k] & ~ack_r[k] & occ[k]!=0: ack_r[k]<=1, dout_k<=mem[rd_ptr[k]], rd_ptr[k]+1.
  - Max one result per consumer per 2 cycles, matching the consumer protocol.
  - dout_k holds its value until the next ack.
- Minimum latency, last ack_l to ack_r (FIFO empty, req_r held high): 2 cycles.
- Consumers never see reordering, duplication or loss. Each consumer sees every result exactly once, in push order.

Optional Feature:
- ASYNC_OPERATOR_FIFO_STATS_EN
- Defined:
  - Adds output ports `count_push` [31:0] (number of pushes) and `count_full` [31:0] (cycles with &has & full).
  - Both reset to 0 and saturate at 2**32-1.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset value check: op=add, input_size=2, depth_log2=2. Hold rst=0 with clk stopped -> req_l=0, ack_r=0, dout=0 immediately. Release rst -> req_l=2'b11 on the next edge.
- Basic add: ack_l pulses with din0=5 and din1=7 in the same cycle, req_r=1 -> one ack_r pulse with dout=12 exactly 2 cycles after ack_l.
- Wrap and unsigned compare:
  - addi immediate=2, data_width=8, din=8'hFF -> dout=8'h01.
  - max with 3 inputs on 8'h80, 8'h7F, 8'h01 -> 8'h80.
- Full backpressure: depth_log2=2, output_size=1, req_r held 0, feed 6 operands -> 4 stored, 5th captured with has=1 and req_l held 0, 6th not requested. Assert req_r -> results delivered in order 0..5, no loss.
- Independent fan-out: output_size=2, input values 0..9. Consumer 0 always requests; consumer 1 requests only every 5th cycle -> both receive 0..9 in order. Producer stalls only when consumer 1 lags by 4.
- Stats (macro defined): run the full-backpressure case -> count_push=6. count_full equals the number of cycles the 5th result waited.
